// File: rtl/framebuffer_scanner_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_scanner_pkg
// Shared CHIP-8 framebuffer geometry and scanner types. The GPU draws into
// the same layout: byte address = screen_start + y*8 + x/8, bit 7 = leftmost.
// Contents:
//   SCREEN_W/H/BYTES      display geometry (64 x 32, 256 bytes)
//   SCREEN_START_DEFAULT  default byte address of row 0, column 0
//   scan_state_t          scanner FSM states
//   fb_byte_addr()        framebuffer byte index -> memory address
// -----------------------------------------------------------------------------
package framebuffer_scanner_pkg;

   localparam int          SCREEN_W               = 64;
   localparam int          SCREEN_H               = 32;
   localparam int          SCREEN_BYTES           = 256;
   localparam logic [15:0] SCREEN_START_DEFAULT   = 16'h0100;
   localparam int          PREFETCH_DEPTH_DEFAULT = 2;

   localparam int PIX_X_W = $clog2(SCREEN_W);            // 6
   localparam int PIX_Y_W = $clog2(SCREEN_H);            // 5
   localparam int PIX_W   = PIX_X_W + PIX_Y_W;           // 11
   localparam int FETCH_W = $clog2(SCREEN_BYTES) + 1;    // holds 0..256

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DONE
   } scan_state_t;

   function automatic logic [15:0] fb_byte_addr(input logic [15:0]        base,
                                                input logic [FETCH_W-1:0] index);
      return base + 16'(index);
   endfunction

endpackage

// File: rtl/framebuffer_scanner_byte_fifo.sv
// -----------------------------------------------------------------------------
// framebuffer_scanner_byte_fifo
// Small show-ahead FIFO (default 2 x 8 bit, depth must be a power of two).
// Push into a full FIFO and pop from an empty one are ignored. Simultaneous
// push and pop leaves the occupancy unchanged.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_data       write request and data
//   pop                   read request; pop_data is the current head
//   pop_data              head entry (valid when !empty)
//   empty, full, count    occupancy status
// -----------------------------------------------------------------------------
module framebuffer_scanner_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; only the pointers and count do,
   // so stale entries are unreachable and the array maps onto plain registers/RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/framebuffer_scanner.sv
// -----------------------------------------------------------------------------
// framebuffer_scanner
// Reads the 64 x 32 CHIP-8 framebuffer byte by byte from main memory and
// serialises it MSB-first into a valid/ready pixel stream with coordinates.
// A 2-byte prefetch FIFO hides memory latency and arbitration stalls.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, ready               frame request (taken only when ready = idle)
//   mem_busy                   another master owns memory; no request issued
//   mem_read, mem_addr         registered one-cycle read strobe and address
//   mem_read_byte              read data, valid the cycle after mem_read
//   pixel_valid, pixel_ready   pixel stream handshake
//   pixel, pixel_x, pixel_y    pixel value and its column/row
//   pixel_last                 marks pixel (63,31)
// -----------------------------------------------------------------------------
module framebuffer_scanner
   import framebuffer_scanner_pkg::*;
#(
   parameter logic [15:0] screen_start   = SCREEN_START_DEFAULT,
   parameter int          prefetch_depth = PREFETCH_DEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         ready,
   input  logic         mem_busy,
   output logic         mem_read,
   output logic [15:0]  mem_addr,
   input  logic [7:0]   mem_read_byte,
   output logic         pixel_valid,
   input  logic         pixel_ready,
   output logic         pixel,
   output logic [5:0]   pixel_x,
   output logic [4:0]   pixel_y,
   output logic         pixel_last
);

   localparam int                 CNT_W     = $clog2(prefetch_depth + 1);
   localparam logic [PIX_W-1:0]   LAST_PIX  = PIX_W'(SCREEN_W * SCREEN_H - 1);
   localparam logic [FETCH_W-1:0] FETCH_END = FETCH_W'(SCREEN_BYTES);

   scan_state_t        state;
   logic [FETCH_W-1:0] fetch_index;
   logic [PIX_W-1:0]   pix_index;
   logic               cap_en;       // read data arrives this cycle
   logic [7:0]         shreg;        // current byte, presented pixel in bit 7
   logic [2:0]         bit_cnt;      // pixels left in shreg after this one

   logic               fifo_empty;
   logic               fifo_full;
   logic [7:0]         fifo_data;
   logic [CNT_W-1:0]   fifo_count;

   logic               outstanding;
   logic               issue;
   logic               fire;
   logic               load;
   logic               last_fire;

   // A read is outstanding from its strobe until its byte is pushed.
   assign outstanding = mem_read | cap_en;

   // With nothing outstanding, "occupancy + outstanding < depth" reduces to a
   // plain occupancy test. A start in IDLE issues the first read at once.
   assign issue = !outstanding && !mem_busy
                  && (fifo_count < CNT_W'(prefetch_depth))
                  && (fetch_index < FETCH_END)
                  && ((state == ST_FETCH) || ((state == ST_IDLE) && start));

   assign fire      = pixel_valid && pixel_ready;
   assign load      = !fifo_empty && (!pixel_valid || (fire && (bit_cnt == 3'd0)));
   assign last_fire = fire && (pix_index == LAST_PIX);

   assign ready      = (state == ST_IDLE);
   assign pixel      = shreg[7];
   assign pixel_x    = pix_index[PIX_X_W-1:0];
   assign pixel_y    = pix_index[PIX_W-1:PIX_X_W];
   assign pixel_last = pixel_valid && (pix_index == LAST_PIX);

   framebuffer_scanner_byte_fifo #(
      .WIDTH (8),
      .DEPTH (prefetch_depth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cap_en),
      .push_data (mem_read_byte),
      .pop       (load),
      .pop_data  (fifo_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values; later statements in the block override earlier ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         fetch_index <= '0;
         pix_index   <= '0;
         mem_read    <= 1'b0;
         mem_addr    <= '0;
         cap_en      <= 1'b0;
         shreg       <= '0;
         bit_cnt     <= '0;
         pixel_valid <= 1'b0;
      end else begin
         mem_read <= 1'b0;
         mem_addr <= '0;
         cap_en   <= mem_read;

         // Output shifter: reload from the FIFO as the last bit leaves.
         if (load) begin
            shreg       <= fifo_data;
            bit_cnt     <= 3'd7;
            pixel_valid <= 1'b1;
         end else if (fire) begin
            if (bit_cnt == 3'd0) begin
               pixel_valid <= 1'b0;
            end else begin
               shreg   <= {shreg[6:0], 1'b0};
               bit_cnt <= bit_cnt - 3'd1;
            end
         end
         if (fire) pix_index <= pix_index + 1'b1;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_FETCH;
                  fetch_index <= '0;
                  pix_index   <= '0;
               end
            end
            ST_FETCH: begin
               if (fetch_index == FETCH_END) state <= ST_DONE;
            end
            default: ;
         endcase

         if (issue) begin
            mem_read    <= 1'b1;
            mem_addr    <= fb_byte_addr(screen_start, fetch_index);
            fetch_index <= fetch_index + 1'b1;
         end

         // Accepting pixel (63,31) ends the frame; pix_index has wrapped to 0.
         if (last_fire) begin
            state       <= ST_IDLE;
            fetch_index <= '0;
         end
      end
   end

   no_fifo_overflow: assert property (@(posedge clk) disable iff (reset) cap_en |-> !fifo_full);

endmodule
